rider_gate_sm: RTL

Parametrised next-generation rider-detect / steer-enable controller. It sits between the load-cell A2D interface and balance_cntrl. It adds several features over the current controller:
- configurable load width, thresholds and settle time;
- a sample-valid qualifier;
- an exact step-off ratio compare;
- a rider-off debounce;
- a true single-cycle rider_off pulse.

en_steer gates steering in balance_cntrl. rider_off notifies power/piezo logic that the rider has left.

---
 rtl/rider_gate_sm.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/rider_gate_sm.sv
// Rider-detect / steer-enable controller between the load-cell A2D and balance_cntrl.
// Qualifies samples, settles the rider before steering, and debounces step-off to a single rider_off pulse.
module rider_gate_sm #(
    parameter int unsigned LOAD_W           = 12,
    parameter int unsigned MIN_RIDER_WEIGHT = 'h200,
    parameter int unsigned HYSTERESIS       = 'h020,
    parameter int unsigned SETTLE_CYCLES    = 65_000_000,
    parameter bit          fast_sim         = 1'b0,
    parameter int unsigned FAST_CYCLES      = 32,
    parameter int unsigned SETTLE_SHIFT     = 2,
    parameter int unsigned STEP_NUM         = 15,
    parameter int unsigned STEP_SHIFT       = 4,
    parameter int unsigned OFF_DEBOUNCE     = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ld_vld,
    input  logic [LOAD_W-1:0] lft_load,
    input  logic [LOAD_W-1:0] rght_load,
    output logic              en_steer,
    output logic              rider_off,
    output logic [LOAD_W-1:0] load_cell_diff,
    output logic [1:0]        sm_state
);

    localparam int unsigned SUM_W  = LOAD_W + 1;
    localparam int unsigned TERM   = fast_sim ? FAST_CYCLES : SETTLE_CYCLES;
    localparam int unsigned TMR_W  = $clog2(TERM + 1);
    localparam int unsigned DB_W   = $clog2(OFF_DEBOUNCE + 1);
    localparam int unsigned NUM_W  = $clog2(STEP_NUM + 1);
    localparam int unsigned LHS_W  = LOAD_W + STEP_SHIFT;
    localparam int unsigned RHS_W  = SUM_W + NUM_W;
    localparam int unsigned PROD_W = (LHS_W > RHS_W) ? LHS_W : RHS_W;
    localparam int unsigned HI_THR = MIN_RIDER_WEIGHT + HYSTERESIS;
    localparam int unsigned LO_THR = MIN_RIDER_WEIGHT - HYSTERESIS;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        WAIT  = 2'b01,
        STEER = 2'b10
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [TMR_W-1:0]  tmr;
    logic [TMR_W-1:0]  tmr_nxt;
    logic [DB_W-1:0]   db_cnt;
    logic [DB_W-1:0]   db_nxt;

    logic [SUM_W-1:0]  sum;
    logic [LOAD_W-1:0] diff_mag;
    logic              sum_gt_min;
    logic              sum_lt_min;
    logic              diff_unsettled;
    logic              diff_stepoff;
    logic              wait_clr;
    logic              off_hit;
    logic              tmr_done;

    // Load arithmetic; every compare is sized so nothing truncates at full-scale inputs.
    always_comb begin
        sum            = SUM_W'(lft_load) + SUM_W'(rght_load);
        diff_mag       = (lft_load >= rght_load) ? (lft_load - rght_load) : (rght_load - lft_load);
        sum_gt_min     = sum > SUM_W'(HI_THR);
        sum_lt_min     = sum < SUM_W'(LO_THR);
        diff_unsettled = SUM_W'(diff_mag) > (sum >> SETTLE_SHIFT);
        diff_stepoff   = (PROD_W'(diff_mag) << STEP_SHIFT) > (PROD_W'(sum) * PROD_W'(STEP_NUM));
    end

    assign load_cell_diff = diff_mag;
    assign sm_state       = state;

    assign wait_clr = ld_vld && (diff_unsettled || sum_lt_min);
    assign off_hit  = ld_vld && sum_lt_min && (db_cnt == DB_W'(OFF_DEBOUNCE - 1));
    assign tmr_done = (tmr == TMR_W'(TERM - 1)) && !wait_clr;

    // Next-state, settle timer and step-off debounce.
    always_comb begin
        next_state = state;
        tmr_nxt    = tmr;
        db_nxt     = db_cnt;
        case (state)
            IDLE: begin
                tmr_nxt = '0;
                db_nxt  = '0;
                if (ld_vld && sum_gt_min) begin
                    next_state = WAIT;
                end
            end
            WAIT: begin
                if (ld_vld) begin
                    db_nxt = sum_lt_min ? (db_cnt + DB_W'(1)) : '0;
                end
                if (wait_clr) begin
                    tmr_nxt = '0;
                end else if (tmr != TMR_W'(TERM)) begin
                    tmr_nxt = tmr + TMR_W'(1);
                end
                if (off_hit) begin
                    next_state = IDLE;
                end else if (ld_vld && diff_unsettled) begin
                    next_state = WAIT;
                end else if (tmr_done) begin
                    next_state = STEER;
                end
            end
            STEER: begin
                // Held at zero so a step-off drop back into WAIT restarts the settle.
                tmr_nxt = '0;
                if (ld_vld) begin
                    db_nxt = sum_lt_min ? (db_cnt + DB_W'(1)) : '0;
                end
                if (off_hit) begin
                    next_state = IDLE;
                end else if (ld_vld && diff_stepoff) begin
                    next_state = WAIT;
                end
            end
            default: begin
                next_state = IDLE;
                tmr_nxt    = '0;
                db_nxt     = '0;
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            tmr       <= '0;
            db_cnt    <= '0;
            en_steer  <= 1'b0;
            rider_off <= 1'b0;
        end else begin
            state     <= next_state;
            tmr       <= tmr_nxt;
            db_cnt    <= db_nxt;
            en_steer  <= (next_state == STEER);
            rider_off <= (next_state == IDLE) && ((state == WAIT) || (state == STEER));
        end
    end

endmodule
